// File: rtl/gol_cell_renderer.sv
// Game of Life pixel stage: prefetches one board row per cell row during hblank
// and renders the board as square cells behind a 2-cycle pipeline.
module gol_cell_renderer #(
  parameter int CELL_SHIFT = 3,
  parameter int BOARD_PX   = 480,
  parameter int GRID_N     = BOARD_PX >> CELL_SHIFT
) (
  input  logic                      clk_vga,
  input  logic                      rst,
  input  logic [9:0]                sx,
  input  logic [9:0]                sy,
  input  logic                      de,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      show_grid,
  output logic                      row_req,
  output logic [$clog2(GRID_N)-1:0] row_addr,
  input  logic                      row_ack,
  input  logic [GRID_N-1:0]         row_data,
  output logic [3:0]                VGA_R,
  output logic [3:0]                VGA_G,
  output logic [3:0]                VGA_B,
  output logic                      VGA_HSYNC,
  output logic                      VGA_VSYNC,
  output logic                      frame_done,
  output logic                      underflow
);

  localparam int         ADDR_W    = $clog2(GRID_N);
  localparam int         COL_W     = 11 - CELL_SHIFT;
  localparam logic [9:0] BOARD_LIM = 10'(BOARD_PX);
  localparam logic [9:0] X_FETCH   = 10'd640;
  localparam logic [9:0] X_LAST    = 10'd799;
  localparam logic [9:0] Y_LAST    = 10'd524;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
  logic [GRID_N-1:0]   buf_q, buf_d;
  logic                buf_valid_q, buf_valid_d;
  logic                underflow_q, underflow_d;
  logic [9:0]          ny;
  logic                fetch_row;

  // Row to prefetch belongs to the next line; line 524 wraps to line 0.
  assign ny        = (sy == Y_LAST) ? 10'd0 : sy + 10'd1;
  assign fetch_row = (ny < BOARD_LIM) && (ny[CELL_SHIFT-1:0] == '0);

  always_comb begin
    state_d     = state_q;
    row_addr_d  = row_addr_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    underflow_d = underflow_q;
    case (state_q)
      S_IDLE: begin
        if (sx == X_FETCH && fetch_row) begin
          state_d    = S_REQ;
          row_addr_d = ADDR_W'(ny >> CELL_SHIFT);
        end
      end
      S_REQ: begin
        if (row_ack) begin
          buf_d       = row_data;
          buf_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (sx == X_LAST) begin
          buf_valid_d = 1'b0;
          underflow_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (sx == 10'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_addr_q  <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_addr_q  <= row_addr_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign row_req   = (state_q == S_REQ);
  assign row_addr  = row_addr_q;
  assign underflow = underflow_q;

  // Stage 1: register timing and track the cell position with counters.
  logic                  s1_de_q, s1_hs_q, s1_vs_q, s1_board_q, s1_right_q, s1_grid_q, s1_fd_q;
  logic [CELL_SHIFT-1:0] s1_sub_y_q;
  logic [CELL_SHIFT-1:0] sub_x_q, sub_x_d;
  logic [COL_W-1:0]      col_q, col_d;

  always_comb begin
    sub_x_d = sub_x_q + CELL_SHIFT'(1);
    col_d   = (&sub_x_q) ? col_q + COL_W'(1) : col_q;
    if (sx == 10'd0) begin
      sub_x_d = '0;
      col_d   = '0;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s1_de_q    <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s1_board_q <= 1'b0;
      s1_right_q <= 1'b0;
      s1_grid_q  <= 1'b0;
      s1_fd_q    <= 1'b0;
      s1_sub_y_q <= '0;
      sub_x_q    <= '0;
      col_q      <= '0;
    end else begin
      s1_de_q    <= de;
      s1_hs_q    <= hsync_in;
      s1_vs_q    <= vsync_in;
      s1_board_q <= (sx < BOARD_LIM) && (sy < BOARD_LIM);
      s1_right_q <= (sx >= BOARD_LIM);
      s1_grid_q  <= show_grid;
      s1_fd_q    <= (sx == BOARD_LIM - 10'd1) && (sy == BOARD_LIM - 10'd1);
      s1_sub_y_q <= sy[CELL_SHIFT-1:0];
      sub_x_q    <= sub_x_d;
      col_q      <= col_d;
    end
  end

  // Cell lookup as a one-hot AND-OR mux over the line buffer.
  logic [GRID_N-1:0] cell_hit;
  logic              cell_live;

  genvar gi;
  generate
    for (gi = 0; gi < GRID_N; gi++) begin : g_cell_sel
      assign cell_hit[gi] = buf_q[gi] && (col_q == COL_W'(gi));
    end
  endgenerate

  assign cell_live = |cell_hit;

  // Stage 2: colour decision and output registers.
  logic [3:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic       hs_q, vs_q, fd_q;

  always_comb begin
    r_d = 4'h0;
    g_d = 4'h0;
    b_d = 4'h0;
    if (s1_de_q && s1_board_q) begin
      if (!buf_valid_q) begin
        r_d = 4'hF;
      end else if (s1_grid_q && (sub_x_q == '0 || s1_sub_y_q == '0)) begin
        r_d = 4'h4;
        g_d = 4'h4;
        b_d = 4'h4;
      end else if (cell_live) begin
        r_d = 4'hF;
        g_d = 4'hF;
        b_d = 4'hF;
      end
    end else if (s1_de_q && s1_right_q) begin
      b_d = 4'h2;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_q  <= 4'h0;
      g_q  <= 4'h0;
      b_q  <= 4'h0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      fd_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= s1_hs_q;
      vs_q <= s1_vs_q;
      fd_q <= s1_fd_q;
    end
  end

  assign VGA_R      = r_q;
  assign VGA_G      = g_q;
  assign VGA_B      = b_q;
  assign VGA_HSYNC  = hs_q;
  assign VGA_VSYNC  = vs_q;
  assign frame_done = fd_q;

endmodule

// File: doc/gol_cell_renderer.md
# gol_cell_renderer

Pixel-generation stage for the Game of Life display, sitting directly downstream of `VGA_DRIVER_480p` and driving the VGA pins. It consumes the driver's `sx`/`sy`/`de`/`hsync`/`vsync`, prefetches one board row per cell row from the board memory with a req/ack handshake during horizontal blanking, and renders the 480x480 board as square cells with optional grid lines. All timing outputs are delayed to match the 2-cycle pixel pipeline.

## Interface
- `CELL_SHIFT`, default 3: cell size is 2^CELL_SHIFT pixels (8).
- `BOARD_PX`, default 480: board edge in pixels.
- `GRID_N`, derived as BOARD_PX >> CELL_SHIFT (60): cells per row and per column.
- `clk_vga`  in  1  25 MHz pixel clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sx`, `sy`  in  10 each  driver position; sx 0..799, sy 0..524.
- `de`, `hsync_in`, `vsync_in`  in  1 each  driver data-enable and syncs (syncs active-low).
- `show_grid`  in  1  draw grid lines.
- `row_req`  out  1  row fetch request.
- `row_addr`  out  clog2(GRID_N)  board row index.
- `row_ack`  in  1  row_data valid this cycle.
- `row_data`  in  GRID_N  cell states; bit i = column i, 1 = live.
- `VGA_R`, `VGA_G`, `VGA_B`  out  4 each  pixel colour.
- `VGA_HSYNC`, `VGA_VSYNC`  out  1 each  delayed syncs.
- `frame_done`  out  1  one-cycle pulse after the last visible board pixel.
- `underflow`  out  1  sticky fetch-miss flag.

## Operation
- Line buffer: GRID_N-bit register plus `buf_valid`.
- Prefetch FSM has three states: IDLE, REQ, DONE.
  - In IDLE, on an input cycle with sx==640, compute ny = (sy==524) ? 0 : sy+1.
  - If ny < BOARD_PX and ny[CELL_SHIFT-1:0]==0, go to REQ. The FSM drives `row_addr` = ny >> CELL_SHIFT and holds `row_req`=1 with `row_addr` stable.
  - In REQ, when `row_ack`=1, load `row_data` into the buffer, set `buf_valid`=1, and go to DONE. `row_req` drops the next cycle.
  - In REQ, if input sx==799 arrives without `row_ack`, abort: `row_req`=0, `buf_valid`=0, `underflow`=1, go to DONE.
  - If `row_ack` and sx==799 occur in the same cycle, the ack wins.
  - DONE returns to IDLE on input sx==0.
- Any `row_ack` received outside REQ is ignored.
- Cell tracking uses counters, not dividers. At sx==0, sub_x=0 and col=0. Otherwise sub_x increments and wraps at 2^CELL_SHIFT−1, and col increments on wrap. sub_y = sy[CELL_SHIFT-1:0].
- Colour rules, in priority order:
  1. `de`=0: all channels 0.
  2. sx<BOARD_PX, sy<BOARD_PX, `buf_valid`=0: R=F, G=0, B=0 (error red).
  3. Board pixel with `show_grid` and (sub_x==0 or sub_y==0): R=G=B=4.
  4. Board pixel with live cell: R=G=B=F. Dead cell: all 0.
  5. Active pixel with sx≥BOARD_PX: R=G=0, B=2.
- `frame_done` is generated from the input cycle with sx==BOARD_PX−1 and sy==BOARD_PX−1.
- `underflow` clears only on `rst`.

## Timing
- Pipeline latency is 2 cycles. Inputs sampled at edge t appear on the RGB, sync and `frame_done` outputs at edge t+2, all mutually aligned.
- `row_req` rises 1 cycle after the sx==640 input is sampled.
- The fetch window runs from input sx==640 to sx==799, so the memory may take up to 158 cycles from `row_req` to `row_ack`.
- Reset values:
  - RGB = 0.
  - `VGA_HSYNC` = 1 and `VGA_VSYNC` = 1 (inactive).
  - `row_req` = 0, `row_addr` = 0, `frame_done` = 0, `underflow` = 0.
  - `buf_valid` = 0, FSM in IDLE, pipeline cleared with syncs inactive.
- Reset mid-fetch drops `row_req` on the next edge. The first row after reset fetches at the next qualifying sx==640.
- Row 0 is fetched at sy==524, sx==640. Wrap from sy 524 to 0 is handled by the ny computation.

## Test plan
- Reset with `rst`=1 for 4 cycles, then release -> outputs at reset values; first `row_req` at sy==524, sx==640 with `row_addr`=0.
- Board with only bit 0 set in row 0, `row_ack` 3 cycles after `row_req`, `show_grid`=0 -> pixel (0..7, 0..7) is F/F/F at output 2 cycles after input; pixel (8,0) is 0; pixel (500,10) is B=2; blanking is 0.
- `show_grid`=1 with an all-live board -> pixels with sx%8==0 or sy%8==0 inside the board are 4/4/4, all others F/F/F.
- `row_ack` never asserted for row 5 -> `row_req` drops after input sx==799; lines 40..47 in the board are red; `underflow`=1 and stays 1 through later good rows.
- Ack at exactly input sx==799 -> buffer loads, `underflow` stays 0.
- Full frame run -> exactly one `frame_done` pulse per frame, 2 cycles after input (479,479); exactly 60 fetches per frame, one per 8 lines, with `row_addr` 0..59 in order.
